angle_sweep: RTL and testbench
==============================

ANGLE_SWEEP -- requirements
Module: angle_sweep

Interface
REQ-001 Parameter: ANGLE_MAX, default 360, angle modulus; all emitted angles lie in 0..ANGLE_MAX-1.
REQ-002 Parameter: CNT_W, default 16, width of count input and internal beat counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  one-cycle request to begin a sweep.
REQ-006 Port: op_sel_in  input  1  operation select, latched at start.
REQ-007 Port: angle_start  input  32  first angle of sweep, unsigned.
REQ-008 Port: angle_step  input  32  increment per beat, unsigned.
REQ-009 Port: count  input  CNT_W  number of angles to emit.
REQ-010 Port: ready  input  1  downstream (LUT stage) accepts current beat.
REQ-011 Port: angle  output  32  current angle presented to LUT.
REQ-012 Port: op_selector  output  1  operation select presented to LUT.
REQ-013 Port: valid  output  1  angle/op_selector hold a beat.
REQ-014 Port: busy  output  1  sweep in progress (RUN or DONE state).
REQ-015 Port: done  output  1  one-cycle pulse at sweep end.
REQ-016 Port: err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: start=1 with angle_start<ANGLE_MAX, angle_step<ANGLE_MAX, count>0 -> RUN; next cycle valid=1, angle=angle_start, op_selector=op_sel_in, busy=1.
REQ-019 IDLE: start=1 with angle_start>=ANGLE_MAX or angle_step>=ANGLE_MAX -> stay IDLE, err=1 for exactly one cycle next cycle, no valid.
REQ-020 IDLE: start=1, inputs legal, count=0 -> DONE directly; no valid beat; done=1 next cycle.
REQ-021 Beat transfer occurs on a rising edge with valid=1 and ready=1; beat counter increments by 1.
REQ-022 valid=1 and ready=0: angle, op_selector, valid held unchanged; no beat lost or skipped.
REQ-023 Next angle = angle+angle_step computed at 33 bits; if result >= ANGLE_MAX, subtract ANGLE_MAX once (wrap-around).
REQ-024 On the transfer of beat number count: RUN -> DONE, valid=0 next cycle; no extra beat emitted.
REQ-025 DONE lasts one cycle: done=1, busy=1, valid=0; then IDLE, busy=0.
REQ-026 start asserted in RUN or DONE ignored; no err, no effect on sweep in progress.
REQ-027 op_sel_in, angle_start, angle_step, count sampled only at accepted start; later input changes have no effect on the sweep.
REQ-028 Beats emitted back-to-back when ready held high: one new angle per cycle, no bubbles.

Reset
REQ-029 rst=1 at rising edge: state IDLE, beat counter 0, angle=0, op_selector=0, valid=0, busy=0, done=0, err=0 next cycle.
REQ-030 rst has priority over start and ready in the same cycle; reset mid-sweep aborts with no done pulse.
REQ-031 First accepted start after reset deassertion runs a complete sweep.

Verification
REQ-032 start=1, angle_start=0, step=90, count=4, ready=1 -> angle 0,90,180,270 on 4 consecutive valid cycles, done pulse on next cycle, busy low after.
REQ-033 angle_start=300, step=45, count=3, ready=1 -> angles 300,345,30 (wrap), then done.
REQ-034 step=90, count=4, ready low 3 cycles while angle=90 -> valid, angle=90 held 3 cycles, sequence resumes 180,270, exactly 4 transfers total.
REQ-035 count=0, legal inputs -> no valid ever, done=1 one cycle after start, busy high that cycle only.
REQ-036 angle_step=360 or angle_start=400 -> err=1 for one cycle, valid and busy stay 0; start during RUN ignored.
REQ-037 rst=1 after 2 transfers of a count=5 sweep -> all outputs 0 next cycle, no done; new start with count=2 emits exactly 2 beats then done.

Source files
------------

// File: rtl/angle_sweep.sv
// Angle sweep generator: emits count angles starting at angle_start, stepping by
// angle_step modulo ANGLE_MAX, to a downstream LUT stage over a valid/ready handshake.
module angle_sweep #(
    parameter int ANGLE_MAX = 360,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sel_in,
    input  logic [31:0]      angle_start,
    input  logic [31:0]      angle_step,
    input  logic [CNT_W-1:0] count,
    input  logic             ready,
    output logic [31:0]      angle,
    output logic             op_selector,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // state | meaning
    // IDLE  | waiting for start; bad start pulses err
    // RUN   | presenting beats, advancing on valid & ready
    // DONE  | one-cycle end of sweep, done pulse
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [32:0] AMAX = 33'(ANGLE_MAX);

    state_t           state;
    logic [31:0]      step_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] beat_cnt;
    logic [32:0]      sum;
    logic [31:0]      next_angle;
    logic             start_ok;

    // Both operands are below ANGLE_MAX, so a single subtract always wraps back in range.
    always_comb begin
        sum        = {1'b0, angle} + {1'b0, step_r};
        next_angle = (sum >= AMAX) ? 32'(sum - AMAX) : sum[31:0];
    end

    assign start_ok = ({1'b0, angle_start} < AMAX) && ({1'b0, angle_step} < AMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            step_r      <= '0;
            count_r     <= '0;
            beat_cnt    <= '0;
            angle       <= '0;
            op_selector <= 1'b0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!start_ok) begin
                            err <= 1'b1;
                        end else begin
                            op_selector <= op_sel_in;
                            step_r      <= angle_step;
                            count_r     <= count;
                            beat_cnt    <= '0;
                            angle       <= angle_start;
                            busy        <= 1'b1;
                            if (count == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= RUN;
                                valid <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (valid && ready) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt + CNT_W'(1) == count_r) begin
                            state <= DONE;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            angle <= next_angle;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_sweep.sv
// Scoreboard bench for angle_sweep: stimulus pushes hand-computed beats/done/err
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_angle_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_sel_in;
    logic [31:0] angle_start;
    logic [31:0] angle_step;
    logic [15:0] count;
    logic        ready;
    logic [31:0] angle;
    logic        op_selector;
    logic        valid;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        int          kind;   // 0 beat, 1 done, 2 err
        logic [31:0] ang;
        logic        op;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    angle_sweep #(.ANGLE_MAX(360), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sel_in(op_sel_in),
        .angle_start(angle_start), .angle_step(angle_step), .count(count),
        .ready(ready), .angle(angle), .op_selector(op_selector), .valid(valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic string kname(input int k);
        return (k == 0) ? "beat" : (k == 1) ? "done" : "err";
    endfunction

    task automatic pop_check(input int kind, input logic [31:0] a, input logic o);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got angle=%0d op=%0b, expected nothing", kname(kind), a, o);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == 0 && (e.ang != a || e.op != o))) begin
                n_fail++;
                $display("FAIL scoreboard: got %s angle=%0d op=%0b, expected %s angle=%0d op=%0b",
                         kname(kind), a, o, kname(e.kind), e.ang, e.op);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) pop_check(0, angle, op_selector);
            if (done)           pop_check(1, 32'd0, 1'b0);
            if (err)            pop_check(2, 32'd0, 1'b0);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic o);
        exp_t e;
        e.kind = 0; e.ang = a; e.op = o;
        exp_q.push_back(e);
    endtask

    task automatic push_evt(input int k);
        exp_t e;
        e.kind = k; e.ang = 32'd0; e.op = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] st,
                            input logic [15:0] c, input logic o);
        @(posedge clk); #1;
        angle_start = s; angle_step = st; count = c; op_sel_in = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (!busy && exp_q.size() == 0) break;
        end
        n_vec++;
        if (i == 60) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%0b pending=%0d, expected busy=0 pending=0",
                     name, busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [4:0] vseq;
        logic [4:0] dseq;
        rst = 1'b1; start = 1'b0; op_sel_in = 1'b0; angle_start = '0;
        angle_step = '0; count = '0; ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {26'd0, angle, op_selector, valid, busy, done, err}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 0,90,180,270 back to back, then done
        push_beat(0, 1); push_beat(90, 1); push_beat(180, 1); push_beat(270, 1); push_evt(1);
        do_start(0, 90, 4, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vseq[i] = valid;
            dseq[i] = done;
        end
        check("b2b_valid", 64'(vseq), 64'b01111);
        check("b2b_done", 64'(dseq), 64'b10000);
        wait_idle("sweep90");

        // wrap-around
        push_beat(300, 0); push_beat(345, 0); push_beat(30, 0); push_evt(1);
        do_start(300, 45, 3, 0);
        wait_idle("wrap");

        // stall with angle 90 held
        push_beat(0, 1); push_beat(90, 1); push_beat(180, 1); push_beat(270, 1); push_evt(1);
        do_start(0, 90, 4, 1);
        @(posedge clk); #1;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", {31'd0, valid, angle}, {31'd0, 1'b1, 32'd90});
        end
        @(posedge clk); #1;
        ready = 1'b1;
        wait_idle("stall");

        // count = 0
        push_evt(1);
        do_start(10, 10, 0, 0);
        @(negedge clk);
        check("cnt0_first", {61'd0, busy, done, valid}, {61'd0, 3'b110});
        @(negedge clk);
        check("cnt0_after", {61'd0, busy, done, valid}, 64'd0);
        wait_idle("cnt0");

        // rejected starts
        push_evt(2);
        do_start(0, 360, 4, 1);
        @(negedge clk);
        check("err_step", {62'd0, busy, valid}, 64'd0);
        wait_idle("err_step");
        push_evt(2);
        do_start(400, 10, 4, 1);
        @(negedge clk);
        check("err_start", {62'd0, busy, valid}, 64'd0);
        wait_idle("err_start");

        // start during RUN ignored, inputs changed after acceptance
        push_beat(10, 0); push_beat(30, 0); push_beat(50, 0); push_evt(1);
        do_start(10, 20, 3, 0);
        angle_start = 400; angle_step = 5; count = 9; op_sel_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("start_in_run");

        // start during DONE ignored
        push_beat(7, 1); push_evt(1);
        do_start(7, 0, 1, 1);
        @(posedge clk); #1;
        angle_start = 5; angle_step = 5; count = 2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("start_in_done");

        // reset after two transfers of a five-beat sweep
        push_beat(0, 1); push_beat(90, 1);
        do_start(0, 90, 5, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset", {26'd0, angle, op_selector, valid, busy, done, err}, 64'd0);
        wait_idle("mid_reset");
        push_beat(0, 0); push_beat(90, 0); push_evt(1);
        do_start(0, 90, 2, 0);
        wait_idle("after_reset");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
